// File: rtl/com_rx.sv
// Packet receiver: waits for a sync byte, decodes the PID and length, writes the payload
// to RAM and checks the trailing CRC5/CRC16.
//   state  | meaning
//   IDLE   | post-reset, always moves on to WAIT
//   WAIT   | discard bytes until sync 0x0F
//   WPID   | decode packet identifier
//   DNUM   | two length bytes
//   WORK   | payload bytes written to RAM
//   CRC5   | one CRC byte
//   CRC16  | two CRC bytes, high first
//   CHECK  | compare received and computed CRC
//   DONE   | fd high, results held until fs drops
module com_rx #(
  parameter logic [15:0] TIMEOUT = 16'd1024,
  parameter logic [11:0] MAXLEN  = 12'hFF0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs,
  output logic        fd,
  input  logic [7:0]  rxd,
  input  logic        rxv,
  input  logic [11:0] ram_init,
  output logic [11:0] ram_txa,
  output logic [7:0]  ram_txd,
  output logic        ram_txe,
  output logic [3:0]  btype,
  output logic [11:0] rlen,
  output logic [1:0]  err
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_WPID, S_DNUM, S_WORK, S_CRC5, S_CRC16, S_CHECK, S_DONE
  } state_t;

  state_t      state_q, state_d, crc_st;
  logic [11:0] base_q, base_d, rlen_q, rlen_d, idx_q, idx_d, txa_q, txa_d, len_w;
  logic [3:0]  btype_q, btype_d;
  logic [1:0]  err_q, err_d;
  logic        ph_q, ph_d, txe_q, txe_d, crc_ok, mon;
  logic [15:0] crc16_q, crc16_d, rcrc_q, rcrc_d, tmr_q, tmr_d;
  logic [4:0]  crc5_q, crc5_d;
  logic [7:0]  txd_q, txd_d;

  function automatic logic [15:0] crc16_upd(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h8005;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [4:0] crc5_upd(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[4] ^ d[i]) r = {r[3:0], 1'b0} ^ 5'h05;
      else             r = {r[3:0], 1'b0};
    end
    return r;
  endfunction

  assign len_w  = {rlen_q[11:8], rxd};
  assign crc_st = (btype_q == 4'b1000) ? S_CRC5 : S_CRC16;
  assign crc_ok = (btype_q == 4'b1000) ? (rcrc_q == {11'd0, crc5_q}) : (rcrc_q == crc16_q);
  assign mon    = (state_q >= S_WPID) && (state_q <= S_CRC16);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    btype_d = btype_q;
    rlen_d  = rlen_q;
    err_d   = err_q;
    idx_d   = idx_q;
    ph_d    = ph_q;
    crc16_d = crc16_q;
    crc5_d  = crc5_q;
    rcrc_d  = rcrc_q;
    tmr_d   = tmr_q;
    txe_d   = 1'b0;
    txa_d   = txa_q;
    txd_d   = txd_q;
    case (state_q)
      S_IDLE: state_d = S_WAIT;
      S_WAIT: begin
        if (fs && rxv && rxd == 8'h0F) begin
          state_d = S_WPID;
          base_d  = ram_init;
          btype_d = 4'b0000;
          rlen_d  = 12'd0;
          err_d   = 2'b00;
          ph_d    = 1'b0;
          crc16_d = 16'hFFFF;
          crc5_d  = 5'h1F;
          tmr_d   = TIMEOUT - 16'd1;
        end
      end
      S_WPID: begin
        if (rxv) begin
          err_d   = 2'b00;
          state_d = S_DONE;
          case (rxd)
            8'h2D:   btype_d = 4'b0001;
            8'hA5:   btype_d = 4'b0010;
            8'hE1:   btype_d = 4'b0011;
            8'hD2:   begin btype_d = 4'b1000; state_d = S_DNUM; end
            8'h96:   begin btype_d = 4'b1101; state_d = S_DNUM; end
            8'h5A:   begin btype_d = 4'b1110; state_d = S_DNUM; end
            default: begin btype_d = 4'b0000; err_d = 2'b10; end
          endcase
        end
      end
      S_DNUM: begin
        if (rxv && !ph_q) begin
          if (rxd[7:4] != 4'h0) begin
            err_d   = 2'b10;
            state_d = S_DONE;
          end else begin
            rlen_d = {rxd[3:0], 8'h00};
            ph_d   = 1'b1;
          end
        end else if (rxv) begin
          rlen_d = len_w;
          ph_d   = 1'b0;
          idx_d  = 12'd0;
          if (len_w > MAXLEN) begin
            err_d   = 2'b10;
            state_d = S_DONE;
          end else if (len_w == 12'd0) state_d = crc_st;
          else                         state_d = S_WORK;
        end
      end
      S_WORK: begin
        if (rxv) begin
          txe_d   = 1'b1;
          txa_d   = base_q + idx_q;
          txd_d   = rxd;
          crc16_d = crc16_upd(crc16_q, rxd);
          crc5_d  = crc5_upd(crc5_q, rxd);
          idx_d   = idx_q + 12'd1;
          if (idx_q == rlen_q - 12'd1) state_d = crc_st;
        end
      end
      S_CRC5: begin
        if (rxv) begin
          rcrc_d  = {8'h00, rxd};
          state_d = S_CHECK;
        end
      end
      S_CRC16: begin
        if (rxv && !ph_q) begin
          rcrc_d[15:8] = rxd;
          ph_d         = 1'b1;
        end else if (rxv) begin
          rcrc_d[7:0] = rxd;
          ph_d        = 1'b0;
          state_d     = S_CHECK;
        end
      end
      S_CHECK: begin
        err_d   = crc_ok ? 2'b00 : 2'b01;
        state_d = S_DONE;
      end
      S_DONE:  if (!fs) state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
    // Idle-cycle watchdog, reloaded by every received byte.
    if (mon) begin
      if (rxv) tmr_d = TIMEOUT - 16'd1;
      else if (tmr_q == 16'd0) begin
        err_d   = 2'b11;
        state_d = S_DONE;
      end else tmr_d = tmr_q - 16'd1;
    end
    if (!fs && state_q != S_DONE && state_q != S_IDLE && state_q != S_WAIT) begin
      state_d = S_WAIT;
      txe_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      base_q  <= 12'd0;
      btype_q <= 4'd0;
      rlen_q  <= 12'd0;
      err_q   <= 2'd0;
      idx_q   <= 12'd0;
      ph_q    <= 1'b0;
      crc16_q <= 16'd0;
      crc5_q  <= 5'd0;
      rcrc_q  <= 16'd0;
      tmr_q   <= 16'd0;
      txe_q   <= 1'b0;
      txa_q   <= 12'd0;
      txd_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      btype_q <= btype_d;
      rlen_q  <= rlen_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      ph_q    <= ph_d;
      crc16_q <= crc16_d;
      crc5_q  <= crc5_d;
      rcrc_q  <= rcrc_d;
      tmr_q   <= tmr_d;
      txe_q   <= txe_d;
      txa_q   <= txa_d;
      txd_q   <= txd_d;
    end
  end

  assign fd      = (state_q == S_DONE);
  assign ram_txe = txe_q;
  assign ram_txd = txd_q;
  assign ram_txa = rst ? txa_q : ram_init;
  assign btype   = btype_q;
  assign rlen    = rlen_q;
  assign err     = err_q;

endmodule

// File: tb/tb_com_rx.sv
// Self-checking bench for com_rx: a packet-level model predicts the RAM writes and the
// final btype/rlen/err; a monitor compares the DUT against it every cycle.
module tb_com_rx;
  localparam logic [15:0] TO = 16'd1024;
  localparam logic [11:0] ML = 12'hFF0;

  logic        clk, rst, fs, fd, rxv, ram_txe;
  logic [7:0]  rxd, ram_txd;
  logic [11:0] ram_init, ram_txa, rlen;
  logic [3:0]  btype;
  logic [1:0]  err;

  com_rx #(.TIMEOUT(TO), .MAXLEN(ML)) dut (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd), .rxd(rxd), .rxv(rxv),
    .ram_init(ram_init), .ram_txa(ram_txa), .ram_txd(ram_txd), .ram_txe(ram_txe),
    .btype(btype), .rlen(rlen), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_wr[$];
  logic [3:0]  exp_btype;
  logic [11:0] exp_rlen;
  logic [1:0]  exp_err;
  logic        fd_armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] crc16_ref(input logic [7:0] d[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (d[i]) begin
      c = c ^ {d[i], 8'h00};
      repeat (8) c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
    end
    return c;
  endfunction

  function automatic logic [4:0] crc5_ref(input logic [7:0] d[$]);
    logic bits[$];
    logic [5:0] r;
    foreach (d[i]) for (int b = 7; b >= 0; b--) bits.push_back(d[i][b]);
    r = 6'h1F;
    foreach (bits[i]) begin
      r = {r[4:0], 1'b0} ^ {5'd0, bits[i]} << 0;
      r[0] = 1'b0;
      if (r[5] ^ bits[i]) r = r ^ 6'h25;
      r[5] = 1'b0;
    end
    return r[4:0];
  endfunction

  // Predicts the outcome of one packet given the bytes after the sync byte; a sequence
  // that ends before the packet is complete is expected to end in a timeout.
  task automatic model_packet(input logic [7:0] q[$], input logic [11:0] base);
    int n, len, p;
    logic [11:0] len12;
    logic [7:0]  pay[$];
    logic        ok;
    n = q.size();
    exp_wr.delete();
    exp_btype = 4'd0; exp_rlen = 12'd0; exp_err = 2'd3; fd_armed = 1'b1;
    if (n < 1) return;
    case (q[0])
      8'h2D: begin exp_btype = 4'b0001; exp_err = 2'd0; return; end
      8'hA5: begin exp_btype = 4'b0010; exp_err = 2'd0; return; end
      8'hE1: begin exp_btype = 4'b0011; exp_err = 2'd0; return; end
      8'hD2: exp_btype = 4'b1000;
      8'h96: exp_btype = 4'b1101;
      8'h5A: exp_btype = 4'b1110;
      default: begin exp_err = 2'd2; return; end
    endcase
    if (n < 2) return;
    if (q[1][7:4] != 4'h0) begin exp_err = 2'd2; return; end
    exp_rlen = {q[1][3:0], 8'h00};
    if (n < 3) return;
    len12 = {q[1][3:0], q[2]};
    exp_rlen = len12;
    if (len12 > ML) begin exp_err = 2'd2; return; end
    len = int'(len12);
    for (int k = 0; k < len; k++) begin
      if (3 + k >= n) return;
      pay.push_back(q[3+k]);
      exp_wr.push_back({base + 12'(k), q[3+k]});
    end
    p = 3 + len;
    if (exp_btype == 4'b1000) begin
      if (n < p + 1) return;
      ok = (q[p] == {3'b000, crc5_ref(pay)});
    end else begin
      if (n < p + 2) return;
      ok = ({q[p], q[p+1]} == crc16_ref(pay));
    end
    exp_err = ok ? 2'd0 : 2'd1;
  endtask

  // Monitor: samples 2 time units after each rising edge.
  initial begin
    logic [19:0] w;
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        check("rst_fd", 32'(fd), 32'd0);
        check("rst_txe", 32'(ram_txe), 32'd0);
        check("rst_txd", 32'(ram_txd), 32'd0);
        check("rst_btype", 32'(btype), 32'd0);
        check("rst_rlen", 32'(rlen), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_txa", 32'(ram_txa), 32'(ram_init));
      end else begin
        if (ram_txe) begin
          if (exp_wr.size() == 0) check("stray_write", 32'(ram_txa), 32'hFFFFFFFF);
          else begin
            w = exp_wr.pop_front();
            check("wr_addr", 32'(ram_txa), 32'(w[19:8]));
            check("wr_data", 32'(ram_txd), 32'(w[7:0]));
          end
        end
        if (fd) begin
          if (!fd_armed) check("unexpected_fd", 32'(fd), 32'd0);
          else begin
            check("done_btype", 32'(btype), 32'(exp_btype));
            check("done_rlen", 32'(rlen), 32'(exp_rlen));
            check("done_err", 32'(err), 32'(exp_err));
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bytes(input logic [7:0] q[$]);
    foreach (q[i]) begin
      rxd = q[i];
      rxv = 1'b1;
      @(negedge clk);
    end
    rxv = 1'b0;
    rxd = 8'h00;
  endtask

  task automatic wait_fd(input int limit, input string name);
    int n;
    n = 0;
    while (!fd && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(fd), 32'd1);
  endtask

  task automatic run_pkt(input logic [11:0] base, input logic [7:0] q[$], input int limit,
                         input string name);
    logic [7:0] f[$];
    ram_init = base;
    model_packet(q, base);
    f.push_back(8'h0F);
    foreach (q[i]) f.push_back(q[i]);
    send_bytes(f);
    wait_fd(limit, name);
  endtask

  task automatic end_pkt();
    fs = 1'b0;
    idle(2);
    fd_armed = 1'b0;
    check("writes_pending", 32'(exp_wr.size()), 32'd0);
    fs = 1'b1;
    idle(1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  q[$];
    logic [7:0]  pay[$];
    logic [15:0] c;
    rst = 1'b0; fs = 1'b0; rxv = 1'b0; rxd = 8'h00; ram_init = 12'hABC;
    idle(3);
    rst = 1'b1;
    fs  = 1'b1;
    idle(2);

    // Control PID preceded by junk; bytes during DONE must be ignored.
    send_bytes('{8'h55, 8'hAA});
    q = '{8'h2D};
    run_pkt(12'h000, q, 2, "ack_fd");
    check("ack_btype", 32'(btype), 32'h1);
    check("ack_err", 32'(err), 32'h0);
    send_bytes('{8'h0F, 8'h96, 8'h00});
    check("done_holds_fd", 32'(fd), 32'd1);
    end_pkt();

    // Three-byte CRC16 packet, then the same with the CRC low byte corrupted.
    pay = '{8'h11, 8'h22, 8'h33};
    c = crc16_ref(pay);
    q = '{8'h96, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, c[15:8], c[7:0]};
    run_pkt(12'h100, q, 4, "d1_fd");
    check("d1_rlen", 32'(rlen), 32'd3);
    check("d1_err", 32'(err), 32'd0);
    check("d1_btype", 32'(btype), 32'hD);
    end_pkt();
    q[7] = q[7] ^ 8'hFF;
    run_pkt(12'h100, q, 4, "badcrc_fd");
    check("badcrc_err", 32'(err), 32'd1);
    end_pkt();

    // Stall after first payload byte.
    q = '{8'hD2, 8'h00, 8'h02, 8'hAA};
    run_pkt(12'h040, q, int'(TO) + 4, "timeout_fd");
    check("timeout_err", 32'(err), 32'd3);
    end_pkt();

    // Address wrap.
    pay = '{8'hC1, 8'hC2};
    c = crc16_ref(pay);
    q = '{8'h96, 8'h00, 8'h02, 8'hC1, 8'hC2, c[15:8], c[7:0]};
    run_pkt(12'hFFF, q, 4, "wrap_fd");
    check("wrap_err", 32'(err), 32'd0);
    end_pkt();

    // Hand-computed CRC literals: CRC5(00)=0F, CRC16(00)=FD02, empty payload = init values.
    q = '{8'hD2, 8'h00, 8'h01, 8'h00, 8'h0F};
    run_pkt(12'h020, q, 4, "c5_fd");
    check("c5_err", 32'(err), 32'd0);
    end_pkt();
    q = '{8'hD2, 8'h00, 8'h00, 8'h1F};
    run_pkt(12'h020, q, 4, "c5_empty_fd");
    check("c5_empty_err", 32'(err), 32'd0);
    end_pkt();
    q = '{8'h5A, 8'h00, 8'h01, 8'h00, 8'hFD, 8'h02};
    run_pkt(12'h030, q, 4, "c16_fd");
    check("c16_err", 32'(err), 32'd0);
    check("c16_btype", 32'(btype), 32'hE);
    end_pkt();
    q = '{8'h5A, 8'h00, 8'h00, 8'hFF, 8'hFF};
    run_pkt(12'h030, q, 4, "c16_empty_fd");
    check("c16_empty_err", 32'(err), 32'd0);
    end_pkt();

    // Format errors.
    q = '{8'h77};
    run_pkt(12'h000, q, 4, "badpid_fd");
    check("badpid_err", 32'(err), 32'd2);
    end_pkt();
    q = '{8'h96, 8'h10};
    run_pkt(12'h000, q, 4, "badlen_fd");
    check("badlen_err", 32'(err), 32'd2);
    end_pkt();
    q = '{8'h96, 8'h0F, 8'hF1};
    run_pkt(12'h000, q, 4, "toolong_fd");
    check("toolong_err", 32'(err), 32'd2);
    check("toolong_rlen", 32'(rlen), 32'hFF1);
    end_pkt();

    // Longest accepted payload.
    pay.delete();
    for (int i = 0; i < int'(ML); i++) pay.push_back(8'(i * 7 + 3));
    c = crc16_ref(pay);
    q = '{8'h96, 8'h0F, 8'hF0};
    foreach (pay[i]) q.push_back(pay[i]);
    q.push_back(c[15:8]);
    q.push_back(c[7:0]);
    run_pkt(12'h800, q, 4, "maxlen_fd");
    check("maxlen_err", 32'(err), 32'd0);
    end_pkt();

    // fs dropped mid-payload: no fd, no later writes.
    ram_init = 12'h100;
    q = '{8'h96, 8'h00, 8'h03, 8'h11};
    model_packet(q, 12'h100);
    fd_armed = 1'b0;
    send_bytes('{8'h0F, 8'h96, 8'h00, 8'h03, 8'h11});
    fs = 1'b0; rxd = 8'h22; rxv = 1'b1;
    @(negedge clk);
    rxv = 1'b0;
    idle(3);
    check("abort_writes", 32'(exp_wr.size()), 32'd0);
    check("abort_fd", 32'(fd), 32'd0);
    fs = 1'b1;
    idle(1);

    // Reset during WORK, then a clean packet.
    ram_init = 12'h200;
    q = '{8'h96, 8'h00, 8'h04, 8'h11, 8'h22};
    model_packet(q, 12'h200);
    fd_armed = 1'b0;
    send_bytes('{8'h0F, 8'h96, 8'h00, 8'h04, 8'h11, 8'h22});
    idle(1);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(2);
    check("rstwork_writes", 32'(exp_wr.size()), 32'd0);
    pay = '{8'h11, 8'h22, 8'h33};
    c = crc16_ref(pay);
    q = '{8'h96, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33, c[15:8], c[7:0]};
    run_pkt(12'h300, q, 4, "after_rst_fd");
    check("after_rst_err", 32'(err), 32'd0);
    end_pkt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
